// File: rtl/dccm_rmw_pkg.sv
// Shared types and helpers for the DCCM read-modify-write controller.
// Holds the FSM state enum, the ECC width and the byte-merge function.
package dccm_rmw_pkg;

  localparam int DCCM_ECC_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    RSP
  } state_t;

  // Byte lanes with be set take new data, the rest keep old data.
  function automatic logic [31:0] byte_merge(
    input logic [3:0]  be,
    input logic [31:0] nd,
    input logic [31:0] od
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = be[b] ? nd[b*8 +: 8] : od[b*8 +: 8];
    end
    return r;
  endfunction

  // Byte enables that need the old word (neither none nor all).
  function automatic logic is_partial(input logic [3:0] be);
    return (be != 4'hF) && (be != 4'h0);
  endfunction

endpackage

// File: rtl/dccm_rmw_secded.sv
// SECDED (39,32) codec: Hamming(38,32) plus an overall parity bit.
// Ports: enc_data->enc_chk encode; dec_word->dec_data/single_err/double_err.
module dccm_rmw_secded
  import dccm_rmw_pkg::*;
(
  input  logic [31:0]           enc_data,
  output logic [DCCM_ECC_W-1:0] enc_chk,
  input  logic [38:0]           dec_word,
  output logic [31:0]           dec_data,
  output logic                  single_err,
  output logic                  double_err
);

  // Codeword position (1..38) of data bit j; powers of two hold check bits.
  function automatic logic [5:0] hpos(input int j);
    int k;
    logic [5:0] r;
    k = 0;
    r = '0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == j) r = 6'(p);
        k++;
      end
    end
    return r;
  endfunction

  function automatic logic [5:0] hchk(input logic [31:0] d);
    logic [5:0] c;
    logic [5:0] ps;
    c = '0;
    for (int j = 0; j < 32; j++) begin
      ps = hpos(j);
      for (int i = 0; i < 6; i++) begin
        if (ps[i]) c[i] = c[i] ^ d[j];
      end
    end
    return c;
  endfunction

  logic [5:0] enc_h;
  logic [5:0] syn;
  logic       par;

  always_comb begin
    enc_h   = hchk(enc_data);
    enc_chk = {^{enc_h, enc_data}, enc_h};
  end

  // Odd overall parity means one flipped bit; even parity with a
  // nonzero syndrome means two.
  always_comb begin
    syn        = hchk(dec_word[31:0]) ^ dec_word[37:32];
    par        = ^dec_word;
    single_err = par;
    double_err = !par && (syn != 6'd0);
    dec_data   = dec_word[31:0];
    for (int j = 0; j < 32; j++) begin
      if (par && (syn == hpos(j))) dec_data[j] = ~dec_word[j];
    end
  end

endmodule

// File: rtl/dccm_rmw_ctl.sv
// DCCM requester: one word request at a time, sub-word writes done as RMW.
// Ports: req_* in, rsp_* out, dccm_* array port. Option: DCCM_RMW_ECC_EN.
module dccm_rmw_ctl
  import dccm_rmw_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int FDATA_W = 39
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [3:0]         req_byteen,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  input  logic               ecc_disable,
  output logic               dccm_wren,
  output logic               dccm_rden,
  output logic [ADDR_W-1:0]  dccm_wr_addr,
  output logic [ADDR_W-1:0]  dccm_rd_addr_lo,
  output logic [ADDR_W-1:0]  dccm_rd_addr_hi,
  output logic [FDATA_W-1:0] dccm_wr_data,
  input  logic [FDATA_W-1:0] dccm_rd_data_lo
);

  state_t              state;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          be_q;
  logic                wren_q;
  logic                rden_q;
  logic [FDATA_W-1:0]  wr_word_q;

  logic [ADDR_W-1:0]     word_addr;
  logic [DATA_W-1:0]     enc_in;
  logic [DATA_W-1:0]     corr_data;
  logic [DATA_W-1:0]     merged;
  logic [DCCM_ECC_W-1:0] enc_chk;
  logic                  dbl_err;
  logic                  addr_unused;

  assign word_addr   = {req_addr[ADDR_W-1:2], 2'b00};
  assign addr_unused = ^req_addr[1:0];
  assign merged      = byte_merge(be_q, wdata_q, corr_data);

  // One encoder serves both the full write (IDLE) and the merge (WAIT).
  assign enc_in = (state == IDLE) ? req_wdata : merged;

`ifdef DCCM_RMW_ECC_EN
  logic [DATA_W-1:0] dec_data;
  logic              sgl_err;
  logic              dbl_raw;
  logic              ecc_unused;

  dccm_rmw_secded u_secded (
    .enc_data   (enc_in),
    .enc_chk    (enc_chk),
    .dec_word   (dccm_rd_data_lo),
    .dec_data   (dec_data),
    .single_err (sgl_err),
    .double_err (dbl_raw)
  );

  assign ecc_unused = sgl_err;
  assign corr_data  = ecc_disable ? dccm_rd_data_lo[DATA_W-1:0] : dec_data;
  assign dbl_err    = !ecc_disable && dbl_raw;
`else
  logic ecc_unused;

  assign enc_chk    = '0;
  assign corr_data  = dccm_rd_data_lo[DATA_W-1:0];
  assign dbl_err    = 1'b0;
  assign ecc_unused = ^{ecc_disable, enc_in,
                        dccm_rd_data_lo[FDATA_W-1:DATA_W]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wr_word_q <= '0;
    end else begin
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= ISSUE;
            req_ready <= 1'b0;
            write_q   <= req_write;
            addr_q    <= word_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_byteen;
            if (!req_write || is_partial(req_byteen)) begin
              rden_q <= 1'b1;
            end else if (req_byteen == 4'hF) begin
              wren_q    <= 1'b1;
              wr_word_q <= {enc_chk, req_wdata};
            end
          end
        end
        ISSUE: begin
          if (!write_q || is_partial(be_q)) begin
            state <= WAIT;
          end else begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (!write_q) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= corr_data;
            rsp_err   <= dbl_err;
          end else if (dbl_err) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            state     <= WRITE;
            wren_q    <= 1'b1;
            wr_word_q <= {enc_chk, merged};
          end
        end
        WRITE: begin
          state     <= RSP;
          rsp_valid <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked during reset so an edge-registered strobe never
  // reaches the array in a reset cycle.
  assign dccm_wren       = wren_q && rst_l;
  assign dccm_rden       = rden_q && rst_l;
  assign dccm_wr_addr    = dccm_wren ? addr_q : '0;
  assign dccm_wr_data    = dccm_wren ? wr_word_q : '0;
  assign dccm_rd_addr_lo = dccm_rden ? addr_q : '0;
  assign dccm_rd_addr_hi = dccm_rden ? addr_q : '0;

endmodule

// File: tb/tb_dccm_rmw_ctl.sv
// Self-checking bench for dccm_rmw_ctl with a behavioural DCCM and
// a word-level reference memory.
module tb_dccm_rmw_ctl;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byteen = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ecc_disable = 1'b0;
  logic        dccm_wren;
  logic        dccm_rden;
  logic [15:0] dccm_wr_addr;
  logic [15:0] dccm_rd_addr_lo;
  logic [15:0] dccm_rd_addr_hi;
  logic [38:0] dccm_wr_data;
  logic [38:0] dccm_rd_data_lo = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  dccm_rmw_ctl dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_byteen      (req_byteen),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .ecc_disable     (ecc_disable),
    .dccm_wren       (dccm_wren),
    .dccm_rden       (dccm_rden),
    .dccm_wr_addr    (dccm_wr_addr),
    .dccm_rd_addr_lo (dccm_rd_addr_lo),
    .dccm_rd_addr_hi (dccm_rd_addr_hi),
    .dccm_wr_data    (dccm_wr_data),
    .dccm_rd_data_lo (dccm_rd_data_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DCCM array model; flip_mask corrupts reads of one word.
  logic [38:0] mem [0:16383];
  logic [13:0] flip_idx = '0;
  logic [38:0] flip_mask = '0;

  always @(posedge clk) begin
    if (dccm_wren) mem[dccm_wr_addr[15:2]] <= dccm_wr_data;
    if (dccm_rden)
      dccm_rd_data_lo <= mem[dccm_rd_addr_lo[15:2]] ^
        ((dccm_rd_addr_lo[15:2] == flip_idx) ? flip_mask : 39'd0);
  end

  // Strobe monitor.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          viol = 0;
  int          last_rd_cyc = 0;
  int          last_wr_cyc = 0;
  logic [15:0] last_rd_lo = '0;
  logic [15:0] last_rd_hi = '0;
  logic [15:0] last_wr_addr = '0;
  logic [38:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (dccm_rden) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      last_rd_lo  = dccm_rd_addr_lo;
      last_rd_hi  = dccm_rd_addr_hi;
    end
    if (dccm_wren) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = dccm_wr_addr;
      last_wr_data = dccm_wr_data;
    end
    if (dccm_rden && dccm_wren) viol++;
    if (!dccm_wren && (dccm_wr_addr != 0 || dccm_wr_data != 0)) viol++;
    if (!dccm_rden && (dccm_rd_addr_lo != 0 || dccm_rd_addr_hi != 0)) viol++;
  end

  // Reference memory of 32-bit words.
  logic [31:0] ref_mem [int];

  // Results of the last transaction.
  int          r_rsp;
  int          r_rd;
  int          r_wr;
  int          r_nrd;
  int          r_nwr;
  logic [31:0] r_data;
  logic        r_err;
  bit          r_to;

  task automatic run_req(input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    int t0;
    int r0;
    int w0;
    int k;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_byteen = be;
    r0 = rd_cnt;
    w0 = wr_cnt;
    r_to = 1'b0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    r_to   = !rsp_valid;
    r_rsp  = cyc - t0;
    r_data = rsp_rdata;
    r_err  = rsp_err;
    r_nrd  = rd_cnt - r0;
    r_nwr  = wr_cnt - w0;
    r_rd   = (r_nrd > 0) ? last_rd_cyc - t0 : -1;
    r_wr   = (r_nwr > 0) ? last_wr_cyc - t0 : -1;
    @(posedge clk);
  endtask

  function automatic logic [31:0] merge_ref(logic [3:0] be, logic [31:0] nd,
                                            logic [31:0] od);
    logic [31:0] r;
    r = od;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = nd[b*8 +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, dccm_wren, dccm_rden} !== 5'b10000
        || rsp_rdata !== 0 || dccm_wr_data !== 0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b wr=%b rd=%b data=%h",
               req_ready, rsp_valid, rsp_err, dccm_wren, dccm_rden, rsp_rdata);
    end
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_write();
    run_req(1'b1, 16'h0104, 32'hDEADBEEF, 4'hF);
    ref_mem[16'h0104 >> 2] = 32'hDEADBEEF;
    checks++;
    if (r_to || r_wr != 1 || r_nwr != 1 || r_nrd != 0 || r_rsp != 2) begin
      failures++;
      $display("FAIL full_write_timing: wr@%0d n=%0d rd=%0d rsp@%0d need 1/1/0/2",
               r_wr, r_nwr, r_nrd, r_rsp);
    end
    checks++;
    if (last_wr_addr !== 16'h0104 || last_wr_data[31:0] !== 32'hDEADBEEF
        || r_data !== 0 || r_err !== 0) begin
      failures++;
      $display("FAIL full_write_data: addr=%h data=%h rsp=%h err=%b",
               last_wr_addr, last_wr_data, r_data, r_err);
    end
`ifndef DCCM_RMW_ECC_EN
    checks++;
    if (last_wr_data[38:32] !== 7'd0) begin
      failures++;
      $display("FAIL no_ecc_check_bits: got %h need 0", last_wr_data[38:32]);
    end
`endif
  endtask

  task automatic test_read_back();
    run_req(1'b0, 16'h0106, 32'h0, 4'h0);
    checks++;
    if (r_to || r_rd != 1 || r_nwr != 0 || r_rsp != 3) begin
      failures++;
      $display("FAIL read_timing: rd@%0d nwr=%0d rsp@%0d need 1/0/3",
               r_rd, r_nwr, r_rsp);
    end
    checks++;
    if (last_rd_lo !== 16'h0104 || last_rd_hi !== 16'h0104
        || r_data !== 32'hDEADBEEF || r_err !== 0) begin
      failures++;
      $display("FAIL read_data: lo=%h hi=%h data=%h err=%b need 0104/DEADBEEF",
               last_rd_lo, last_rd_hi, r_data, r_err);
    end
  endtask

  task automatic test_partial_write();
    run_req(1'b1, 16'h0104, 32'h0000AA00, 4'h2);
    ref_mem[16'h0104 >> 2] = merge_ref(4'h2, 32'h0000AA00,
                                       ref_mem[16'h0104 >> 2]);
    checks++;
    if (r_to || r_rd != 1 || r_wr != 3 || r_rsp != 4 || r_nwr != 1) begin
      failures++;
      $display("FAIL partial_timing: rd@%0d wr@%0d rsp@%0d need 1/3/4",
               r_rd, r_wr, r_rsp);
    end
    checks++;
    if (last_wr_data[31:0] !== 32'hDEADAAEF || last_wr_addr !== 16'h0104
        || r_data !== 0) begin
      failures++;
      $display("FAIL partial_data: got %h need DEADAAEF", last_wr_data[31:0]);
    end
  endtask

  task automatic test_ecc();
    logic [31:0] exp;
    flip_idx  = 14'h41;
    flip_mask = 39'h20;
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
`ifdef DCCM_RMW_ECC_EN
    exp = ref_mem[14'h41];
`else
    exp = ref_mem[14'h41] ^ 32'h20;
`endif
    checks++;
    if (r_to || r_data !== exp || r_err !== 0) begin
      failures++;
      $display("FAIL ecc_single_read: got %h err=%b need %h err=0",
               r_data, r_err, exp);
    end
`ifdef DCCM_RMW_ECC_EN
    ecc_disable = 1'b1;
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
    ecc_disable = 1'b0;
    checks++;
    if (r_data !== (ref_mem[14'h41] ^ 32'h20) || r_err !== 0) begin
      failures++;
      $display("FAIL ecc_disable_raw: got %h err=%b", r_data, r_err);
    end
    run_req(1'b1, 16'h0104, 32'h12000000, 4'h8);
    ref_mem[14'h41] = merge_ref(4'h8, 32'h12000000, ref_mem[14'h41]);
    flip_mask = '0;
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
    checks++;
    if (r_data !== ref_mem[14'h41] || r_err !== 0) begin
      failures++;
      $display("FAIL ecc_merge_corrected: got %h need %h",
               r_data, ref_mem[14'h41]);
    end
    flip_mask = 39'h220;
    run_req(1'b1, 16'h0104, 32'h00000077, 4'h1);
    checks++;
    if (r_to || r_err !== 1 || r_nwr != 0 || r_rsp != 3 || r_data !== 0) begin
      failures++;
      $display("FAIL ecc_double_rmw: err=%b nwr=%0d rsp@%0d need 1/0/3",
               r_err, r_nwr, r_rsp);
    end
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
    checks++;
    if (r_err !== 1) begin
      failures++;
      $display("FAIL ecc_double_read: err=%b need 1", r_err);
    end
`endif
    flip_mask = '0;
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
    checks++;
    if (r_data !== ref_mem[14'h41] || r_err !== 0) begin
      failures++;
      $display("FAIL ecc_clean_read: got %h need %h", r_data, ref_mem[14'h41]);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    int w0;
    int k;
    logic [31:0] exp;
    exp = ref_mem[14'h41];
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0104;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 16'h0300;
      req_byteen = 4'hF;
      req_wdata  = $urandom;
      checks++;
      if (rsp_valid !== 1 || rsp_rdata !== exp || req_ready !== 0) begin
        failures++;
        $display("FAIL backpressure_hold%0d: vld=%b data=%h rdy=%b need %h",
                 i, rsp_valid, rsp_rdata, req_ready, exp);
      end
      if (i < 3) @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1 || rd_cnt != r0 || wr_cnt != w0) begin
      failures++;
      $display("FAIL backpressure_release: vld=%b rdy=%b drd=%0d dwr=%0d",
               rsp_valid, req_ready, rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 16'h0104;
    req_wdata  = 32'h000000CC;
    req_byteen = 4'h1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || dccm_wren !== 0 || dccm_rden !== 0
        || rsp_valid !== 0) begin
      failures++;
      $display("FAIL reset_mid_rmw_state: rdy=%b wr=%b rd=%b vld=%b",
               req_ready, dccm_wren, dccm_rden, rsp_valid);
    end
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL reset_mid_rmw_nowrite: writes=%0d need 0", wr_cnt - w0);
    end
    run_req(1'b1, 16'h0104, 32'h55555555, 4'h0);
    checks++;
    if (r_to || r_rsp != 2 || r_nrd != 0 || r_nwr != 0 || r_data !== 0) begin
      failures++;
      $display("FAIL be0_write: rsp@%0d nrd=%0d nwr=%0d need 2/0/0",
               r_rsp, r_nrd, r_nwr);
    end
    run_req(1'b0, 16'h0104, 32'h0, 4'h0);
    checks++;
    if (r_data !== ref_mem[14'h41]) begin
      failures++;
      $display("FAIL reset_mid_rmw_data: got %h need %h",
               r_data, ref_mem[14'h41]);
    end
  endtask

  task automatic test_random();
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          idx;
    int          exp_rsp;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      run_req(1'b1, 16'(16'h0200 + i * 4), d, 4'hF);
      ref_mem[(16'h0200 >> 2) + i] = d;
    end
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(7);
      a   = 16'(16'h0200 + idx * 4 + $urandom_range(3));
      w   = 1'($urandom_range(1));
      d   = $urandom;
      be  = 4'($urandom_range(15));
      ecc_disable = 1'($urandom_range(1));
      run_req(w, a, d, be);
      idx = idx + (16'h0200 >> 2);
      if (!w) exp_rsp = 3;
      else if (be == 4'hF || be == 4'h0) exp_rsp = 2;
      else exp_rsp = 4;
      checks++;
      if (r_to || r_rsp != exp_rsp || r_err !== 0) begin
        failures++;
        $display("FAIL random_lat%0d: rsp@%0d need %0d err=%b",
                 n, r_rsp, exp_rsp, r_err);
      end
      if (w) begin
        ref_mem[idx] = merge_ref(be, d, ref_mem[idx]);
      end else begin
        checks++;
        if (r_data !== ref_mem[idx]) begin
          failures++;
          $display("FAIL random_read%0d: addr=%h got %h need %h",
                   n, a, r_data, ref_mem[idx]);
        end
      end
    end
    ecc_disable = 1'b0;
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL strobe_rules: violations=%0d need 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_read_back();
    test_partial_write();
    test_ecc();
    test_backpressure();
    test_reset_mid_rmw();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dccm_rmw_ctl.md
Name: dccm_rmw_ctl

Overview:
- Requester-side controller that drives the DCCM array port: dccm_wren, dccm_rden, write/read addresses and dccm_wr_data. It consumes dccm_rd_data_lo.
- Serves one outstanding word request from a DMA/debug-style master over a valid/ready handshake.
- Converts sub-word (byte-enabled) writes into read-modify-write sequences.
- Returns read data or write completion on a response channel that supports backpressure.

Parameters:
- ADDR_W, 16, DCCM byte-address width; matches RV_DCCM_BITS.
- DATA_W, 32, data word width.
- FDATA_W, 39, stored word width: data plus 7 ECC bits; matches RV_DCCM_FDATA_WIDTH.

Ports:
- clk  in  1  core clock.
- rst_l  in  1  reset; one clock; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  DATA_W  write data.
- req_byteen  in  4  write byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  DATA_W  read data (corrected); 0 for writes.
- rsp_err  out  1  uncorrectable ECC error.
- ecc_disable  in  1  suppress ECC check/correct.
- dccm_wren  out  1  array write strobe.
- dccm_rden  out  1  array read strobe.
- dccm_wr_addr  out  ADDR_W  write address, [1:0]=0.
- dccm_rd_addr_lo  out  ADDR_W  read address, [1:0]=0.
- dccm_rd_addr_hi  out  ADDR_W  equals dccm_rd_addr_lo.
- dccm_wr_data  out  FDATA_W  write word, data plus ECC.
- dccm_rd_data_lo  in  FDATA_W  read word; valid the cycle after dccm_rden.

Behaviour:
- States: IDLE, ISSUE, WAIT, WRITE, RSP.
- Reset values: state=IDLE; all outputs 0 except req_ready=1.
- Any state with rst_l=0 at a clock edge goes to IDLE. No DCCM strobe is driven during a reset cycle. An in-flight RMW is abandoned with no write.
- IDLE: req_ready=1. If req_valid=1, capture write/addr/wdata/byteen and go to ISSUE.
- ISSUE:
  - Read, or write with byteen neither 0xF nor 0x0: dccm_rden=1, read addresses = captured word address; go to WAIT.
  - Write with byteen=0xF: dccm_wren=1, dccm_wr_data=encode(wdata); go to RSP.
  - Write with byteen=0x0: no array access; go to RSP.
- WAIT: sample dccm_rd_data_lo and check/correct it.
  - Read: capture corrected data and the err flag; go to RSP.
  - Partial write with uncorrectable error: set err, perform no write; go to RSP.
  - Partial write otherwise: merged = per-byte select(byteen ? wdata : corrected); go to WRITE.
- WRITE: dccm_wren=1, dccm_wr_data=encode(merged); go to RSP.
- RSP: rsp_valid=1, held stable until rsp_ready=1, then go to IDLE. req_ready is 0 in every state except IDLE. rsp_rdata=0 for writes.
- Latency, with acceptance at cycle T and rsp_ready=1:
  - Read: rden at T+1, rsp_valid at T+3.
  - Full write: wren at T+1, rsp_valid at T+2.
  - Partial write: rden at T+1, wren at T+3, rsp_valid at T+4.
  - byteen=0 write: rsp_valid at T+2.
- dccm_wren and dccm_rden are never asserted in the same cycle.
- Address and write-data outputs are 0 when their strobe is low.

Optional Feature:
- Macro DCCM_RMW_ECC_EN.
- Defined:
  - dccm_wr_data[38:32] carries the SECDED check bits.
  - Read data is checked. A single-bit error is corrected silently and the corrected value is used for both response and merge. A double-bit error sets rsp_err.
  - ecc_disable=1 bypasses check and correction: raw data is used and rsp_err=0. Check bits are still generated on writes.
- Undefined:
  - dccm_wr_data[38:32]=0.
  - Raw read data [31:0] is used.
  - rsp_err is tied to 0 and ecc_disable is ignored.

Decomposition:
- Package dccm_rmw_pkg holds:
  - State enum.
  - DCCM_ECC_W=7.
  - Byte-merge function.
- One sub-module, dccm_rmw_secded: combinational encode of 32 data bits to 7 check bits, and a decode that outputs corrected data, single_err and double_err. It is instantiated only under DCCM_RMW_ECC_EN.

Test Plan:
1. Full write: addr 0x0104, wdata 0xDEADBEEF, byteen 0xF -> one wren at T+1 with wr_addr 0x0104; rsp_valid at T+2 with rsp_rdata 0 and rsp_err 0.
2. Read-back: read 0x0106 after test 1 -> rden with rd_addr_lo = rd_addr_hi = 0x0104; rsp_rdata 0xDEADBEEF at T+3.
3. Partial write: byteen 0x2, wdata 0x0000AA00, over 0xDEADBEEF -> rden, then wren with data 0xDEADAAEF; rsp_valid at T+4.
4. ECC, macro defined: flip bit 5 of the stored word, then read -> rsp_rdata = original value, rsp_err 0. Flip bits 5 and 9, then do a partial write -> rsp_err 1 and no wren.
5. Backpressure: hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
6. Reset mid-RMW: pull rst_l low in WAIT -> no wren; next cycle req_ready=1 and all strobes are 0. A byteen=0 write returns rsp_valid at T+2 with no DCCM strobe.
